// File: rtl/tempo_pkg.sv
// -----------------------------------------------------------------------------
// tempo_pkg
// Shared definitions for the keypad time-entry path.
//   BCD_W        width of one BCD digit
//   MAX_DIGITS   digit_count saturates here (MM:SS = 4 digits)
//   KEY_W        number of raw keypad lines (digits 0..9)
//   state_e      entry sequencer states
// -----------------------------------------------------------------------------
package tempo_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 4;
  localparam int KEY_W      = 10;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  typedef logic [BCD_W-1:0] bcd_t;

endpackage

// File: rtl/codificador_priori.sv
// -----------------------------------------------------------------------------
// codificador_priori
// Priority encoder from the 10-line keypad to a BCD digit. When several
// keys are set, the highest-numbered one wins. An all-zero keypad gives 0.
// Ports:
//   keypad_i   [9:0]  key lines, bit i = digit i
//   enablen_i         1 forces the output to 0
//   bcd_o      [3:0]  encoded digit
// -----------------------------------------------------------------------------
module codificador_priori
  import tempo_pkg::*;
(
  input  logic [KEY_W-1:0] keypad_i,
  input  logic             enablen_i,
  output bcd_t             bcd_o
);

  // Ascending scan: a later (higher) set bit overwrites an earlier one,
  // so the highest set bit determines the result.
  always_comb begin
    bcd_o = '0;
    if (!enablen_i) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (keypad_i[i]) begin
          bcd_o = BCD_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/controle_entrada_tempo.sv
// -----------------------------------------------------------------------------
// controle_entrada_tempo
// Keypad time-entry sequencer (MM:SS). Debounces the keypad, accepts each
// press once, encodes it to BCD and shifts it into a 4-digit register
// right-to-left, strobing dado_valido for one cycle per accepted digit.
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high
//   keypad      [9:0]   raw keys, bit i = digit i
//   enablen             1 = entry disabled (FSM parked in WAIT_RELEASE)
//   clear               synchronous clear of the entered time
//   sec_ones..min_tens  BCD digits, sec_ones newest
//   dado_valido         one-cycle pulse when the digits update
//   digit_count [2:0]   digits since clear, saturates at 4
// -----------------------------------------------------------------------------
module controle_entrada_tempo
  import tempo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       enablen,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       dado_valido,
  output logic [2:0] digit_count
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_REL_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       COUNT_MAX    = 3'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bcd_t sec_ones_q, sec_ones_d;
  bcd_t sec_tens_q, sec_tens_d;
  bcd_t min_ones_q, min_ones_d;
  bcd_t min_tens_q, min_tens_d;
  logic       dv_q, dv_d;
  logic [2:0] count_q, count_d;

  logic shift_en;
  bcd_t key_bcd;

  // The encoder looks at the latched key, so the digit shifted in is the
  // one that survived debouncing, not whatever is on the pins at capture.
  codificador_priori u_codificador (
    .keypad_i  (key_q),
    .enablen_i (1'b0),
    .bcd_o     (key_bcd)
  );

  // State register plus the debounce bookkeeping that travels with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. clear and enablen both park the FSM in WAIT_RELEASE
  // so that a key still held when they drop is never accepted. In DEBOUNCE
  // the counter reaching DEBOUNCE_CYCLES is checked before incrementing,
  // which puts the digit update DEBOUNCE_CYCLES+1 edges after first sample.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    if (clear || enablen) begin
      state_d = WAIT_RELEASE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (keypad != '0) begin
            key_d   = keypad;
            cnt_d   = CNT_ONE;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (keypad == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (keypad != key_q) begin
            key_d = keypad;
            cnt_d = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        CAPTURE: begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
        WAIT_RELEASE: begin
          if (keypad != '0) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_REL_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: the shift happens on the edge leaving CAPTURE unless
  // clear or enablen pre-empts it; the strobe is registered alongside.
  always_comb begin
    shift_en   = (state_q == CAPTURE) && !clear && !enablen;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    count_d    = count_q;
    dv_d       = shift_en;
    if (clear) begin
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_ones_d = '0;
      min_tens_d = '0;
      count_d    = '0;
    end else if (shift_en) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = key_bcd;
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 3'd1;
      end
    end
  end

  // Digit shift register, strobe and digit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
      dv_q       <= 1'b0;
      count_q    <= '0;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      dv_q       <= dv_d;
      count_q    <= count_d;
    end
  end

  assign sec_ones    = sec_ones_q;
  assign sec_tens    = sec_tens_q;
  assign min_ones    = min_ones_q;
  assign min_tens    = min_tens_q;
  assign dado_valido = dv_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_controle_entrada_tempo.sv
// -----------------------------------------------------------------------------
// tb_controle_entrada_tempo
// Bench for the keypad time-entry sequencer. Outputs are packed as
// {min_tens, min_ones, sec_tens, sec_ones, dado_valido, digit_count}.
// -----------------------------------------------------------------------------
module tb_controle_entrada_tempo;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       enablen = 1'b0;
  logic [9:0] keypad = '0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       dado_valido;
  logic [2:0] digit_count;

  int errors = 0;
  int checks = 0;

  // Reference model: the entered time as a decimal number (calculator
  // style), plus a description of the keypad in terms of sample runs.
  int         mTime = 0;
  int         mCount = 0;
  bit         mDv = 0;
  bit         mLocked = 0;
  int         mZeroRun = 0;
  int         mRun = 0;
  logic [9:0] mRunKey = '0;
  bit         mPending = 0;

  typedef struct {
    logic        rst;
    logic        clr;
    logic        en;
    logic [9:0]  key;
    logic [19:0] expOut;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  controle_entrada_tempo #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keypad      (keypad),
    .enablen     (enablen),
    .clear       (clear),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .dado_valido (dado_valido),
    .digit_count (digit_count)
  );

  // Highest pressed key, scanning from the top down.
  function automatic int topDigit(logic [9:0] k);
    for (int i = 9; i >= 0; i--) begin
      if (k[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [19:0] packModel(int t, int c, bit dv);
    return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10), dv, 3'(c)};
  endfunction

  // One rising edge of the reference model with the current inputs.
  task automatic modelStep();
    if (reset) begin
      mTime = 0; mCount = 0; mDv = 0; mLocked = 0;
      mZeroRun = 0; mRun = 0; mRunKey = '0; mPending = 0;
    end else begin
      mDv = 0;
      if (clear || enablen) begin
        if (clear) begin
          mTime  = 0;
          mCount = 0;
        end
        mLocked = 1; mZeroRun = 0; mRun = 0; mPending = 0;
      end else if (mPending) begin
        mTime = (mTime * 10 + topDigit(mRunKey)) % 10000;
        if (mCount < 4) mCount++;
        mDv = 1; mPending = 0; mLocked = 1; mZeroRun = 0; mRun = 0;
      end else if (mLocked) begin
        if (keypad == '0) begin
          mZeroRun++;
          if (mZeroRun == DEB) begin
            mLocked  = 0;
            mZeroRun = 0;
          end
        end else begin
          mZeroRun = 0;
        end
      end else begin
        if (keypad == '0) begin
          mRun = 0;
        end else if (mRun > 0 && keypad == mRunKey) begin
          mRun++;
          if (mRun == DEB + 1) mPending = 1;
        end else begin
          mRunKey = keypad;
          mRun    = 1;
        end
      end
    end
  endtask

  task automatic checkOutput(string name, logic [19:0] expv);
    logic [19:0] act;
    act = {min_tens, min_ones, sec_tens, sec_ones, dado_valido, digit_count};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got digits=%h dv=%b cnt=%0d, expected digits=%h dv=%b cnt=%0d",
               name, act[19:4], act[3], act[2:0], expv[19:4], expv[3], expv[2:0]);
    end
  endtask

  // Drive on the falling edge, advance the model on the rising edge and
  // compare shortly after it.
  task automatic applyStimulus(logic r, logic c, logic e, logic [9:0] k);
    @(negedge clk);
    reset = r; clear = c; enablen = e; keypad = k;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("model", packModel(mTime, mCount, mDv));
  endtask

  task automatic pressKey(logic [9:0] k, int hold, int rel);
    for (int i = 0; i < hold; i++) applyStimulus(1'b0, 1'b0, 1'b0, k);
    for (int i = 0; i < rel; i++)  applyStimulus(1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    bit dvSeen;
    logic [9:0] rk;
    int hold, rel;
    bit epEn;

    // Reset, then key 5 held: first sample on vector 1, digit and strobe
    // visible after the fifth edge from there (vector 6), then no repeat.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 10'h000, {16'h0000, 1'b0, 3'd0}};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0000, 1'b0, 3'd0}};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0000, 1'b0, 3'd0}};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0000, 1'b0, 3'd0}};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0000, 1'b0, 3'd0}};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0000, 1'b0, 3'd0}};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0005, 1'b1, 3'd1}};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0005, 1'b0, 3'd1}};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 10'h020, {16'h0005, 1'b0, 3'd1}};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 10'h000, {16'h0005, 1'b0, 3'd1}};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].clr, tbl[i].en, tbl[i].key);
      checkOutput($sformatf("vec%0d", i), tbl[i].expOut);
    end

    // Sequence 1,2,3,0,9 with overflow on the fifth digit.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
    pressKey(10'd0, 0, 5);
    pressKey(10'b0000000010, 7, 5);
    pressKey(10'b0000000100, 7, 5);
    pressKey(10'b0000001000, 7, 5);
    pressKey(10'b0000000001, 7, 5);
    checkOutput("four_digits", {16'h1230, 1'b0, 3'd4});
    pressKey(10'b1000000000, 7, 5);
    checkOutput("overflow", {16'h2309, 1'b0, 3'd4});

    // Bouncing contact never reaches a stable run.
    dvSeen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, (i % 2 == 0) ? 10'h020 : 10'h000);
      if (dado_valido) dvSeen = 1;
    end
    pressKey(10'd0, 0, 5);
    checks++;
    if (dvSeen) begin
      errors++;
      $display("[TB] FAIL bounce_pulse: got dv pulse=1, expected 0");
    end
    checkOutput("bounce_digits", {16'h2309, 1'b0, 3'd4});

    // Multiple keys: highest wins. Then the same press with entry disabled.
    pressKey(10'b1000001001, 7, 5);
    checkOutput("multi_key", {16'h3099, 1'b0, 3'd4});
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 10'b1000001001);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd0);
    pressKey(10'd0, 0, 5);
    checkOutput("enablen_hold", {16'h3099, 1'b0, 3'd4});

    // clear with a key held: zeroed, no strobe, no capture until re-press.
    pressKey(10'h004, 3, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h004);
    checkOutput("clear_now", {16'h0000, 1'b0, 3'd0});
    pressKey(10'h004, 8, 5);
    checkOutput("clear_held", {16'h0000, 1'b0, 3'd0});
    pressKey(10'h004, 7, 5);
    checkOutput("clear_repress", {16'h0002, 1'b0, 3'd1});

    // Reset in the middle of debouncing aborts the press.
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h080);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h080);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h080);
    checkOutput("reset_mid", {16'h0000, 1'b0, 3'd0});
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    pressKey(10'h080, 7, 5);
    checkOutput("after_reset", {16'h0007, 1'b0, 3'd1});

    // Randomized episodes checked cycle-by-cycle against the model.
    for (int ep = 0; ep < 60; ep++) begin
      rk   = 10'($urandom_range(1, 1023));
      hold = $urandom_range(1, 9);
      rel  = $urandom_range(0, 6);
      epEn = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 5) == 0) rk = 10'($urandom_range(1, 1023));
        applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0), epEn, rk);
      end
      for (int i = 0; i < rel; i++) begin
        applyStimulus(1'b0, ($urandom_range(0, 29) == 0), epEn, 10'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
